// File: rtl/qpu_tcm_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Package  : qpu_tcm_ctrl_pkg
// Purpose  : Shared constants, light-sleep state encoding and a width helper
//            for the TCM SRAM controller and its response FIFO.
// Contents : QPU_*_RAM_* default macro geometries, ls_state_e, clog2_min1().
// Revision : 1.0 - initial release
//==============================================================================
package qpu_tcm_ctrl_pkg;

   // Default TCM macro geometry (word address width / data width).
   localparam int QPU_DTCM_RAM_AW = 12;
   localparam int QPU_DTCM_RAM_DW = 32;
   localparam int QPU_ITCM_RAM_AW = 12;
   localparam int QPU_ITCM_RAM_DW = 32;

   // Light-sleep controller states.
   typedef enum logic [0:0] {
      LS_AWAKE = 1'b0,
      LS_SLEEP = 1'b1
   } ls_state_e;

   // Bit width needed to index v items, never less than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage : qpu_tcm_ctrl_pkg
`default_nettype wire

// File: rtl/qpu_tcm_ctrl_rsp_fifo.sv
`default_nettype none
//==============================================================================
// Module   : qpu_tcm_rsp_fifo
// Purpose  : Synchronous DEPTH-entry response FIFO. Pointers wrap modulo
//            DEPTH; the occupancy count is exported so the controller can
//            decide whether another command fits.
// Ports    : clk         clock
//            rst_n       synchronous reset, active low
//            push_i      write push_data_i at this edge
//            push_data_i entry to write
//            pop_i       retire the head entry at this edge
//            head_o      current head entry
//            cnt_o       number of valid entries
// Revision : 1.0 - initial release
//==============================================================================
module qpu_tcm_rsp_fifo
   import qpu_tcm_ctrl_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_o,
   output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

   localparam int PW = clog2_min1(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;

   // DEPTH need not be a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through cnt_q.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o = mem_q[rd_ptr_q];
   assign cnt_o  = cnt_q;

endmodule : qpu_tcm_rsp_fifo
`default_nettype wire

// File: rtl/qpu_tcm_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : qpu_tcm_ctrl
// Purpose  : Initiator-side controller for one TCM SRAM macro. Accepts word
//            read/write commands, drives the SRAM pins combinationally from
//            the accepted command, captures dout one cycle later and returns
//            one in-order response per command through a small FIFO. Enters
//            light sleep after LS_IDLE idle cycles and wakes on cmd_valid.
// Ports    : clk, rst_n                       clock, sync active-low reset
//            cmd_valid_i/cmd_ready_o          command handshake
//            cmd_read_i/addr/wdata/wmask      command payload
//            rsp_valid_o/rsp_ready_i          response handshake
//            rsp_read_o/rsp_rdata_o           response payload
//            ram_cs/we/addr/wem/din_o         SRAM access pins
//            ram_dout_i                       SRAM read data (cs cycle + 1)
//            ram_ls_o/ram_ds_o/ram_sd_o       SRAM power pins
// Revision : 1.0 - initial release
//==============================================================================
module qpu_tcm_ctrl
   import qpu_tcm_ctrl_pkg::*;
#(
   parameter int AW      = QPU_DTCM_RAM_AW,
   parameter int DW      = QPU_DTCM_RAM_DW,
   parameter int MW      = DW / 8,
   parameter int DEPTH   = 2,
   parameter int LS_IDLE = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_read_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [DW-1:0] cmd_wdata_i,
   input  logic [MW-1:0] cmd_wmask_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic          rsp_read_o,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          ram_cs_o,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [MW-1:0] ram_wem_o,
   output logic [DW-1:0] ram_din_o,
   input  logic [DW-1:0] ram_dout_i,
   output logic          ram_ls_o,
   output logic          ram_ds_o,
   output logic          ram_sd_o
);

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int OW  = CW + 1;
   localparam int ICW = clog2_min1(LS_IDLE + 1);

   logic            acc;
   logic            pop;
   logic [CW-1:0]   fifo_cnt;
   logic [DW:0]     fifo_head;
   logic [DW:0]     push_data;
   logic [OW-1:0]   occ;
   logic            idle;

   logic            s1_vld_q;
   logic            s1_read_q;
   ls_state_e       ls_state_q, ls_state_d;
   logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;

   //---------------------------------------------------------------------------
   // Command acceptance. Occupancy counts the response still in stage 1 plus
   // everything in the FIFO, less the entry leaving this cycle, so a command
   // is only taken when its response is guaranteed a FIFO slot. Ready never
   // looks at cmd_valid_i.
   //---------------------------------------------------------------------------
   assign occ         = OW'(fifo_cnt) + OW'(s1_vld_q) - OW'(pop);
   assign cmd_ready_o = rst_n & (ls_state_q == LS_AWAKE) & (occ < OW'(DEPTH));
   assign acc         = cmd_valid_i & cmd_ready_o;

   // SRAM pins follow the command directly; cs only on an accepted command.
   assign ram_cs_o   = acc;
   assign ram_we_o   = acc & ~cmd_read_i;
   assign ram_addr_o = cmd_addr_i;
   assign ram_din_o  = cmd_wdata_i;
   assign ram_wem_o  = cmd_read_i ? '0 : cmd_wmask_i;
   assign ram_ds_o   = 1'b0;
   assign ram_sd_o   = 1'b0;

   //---------------------------------------------------------------------------
   // Stage 1: remembers that the SRAM was accessed last cycle, so dout is
   // captured into the FIFO exactly when it is valid.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_read_q <= 1'b0;
      end else begin
         s1_vld_q  <= acc;
         s1_read_q <= cmd_read_i;
      end
   end

   assign push_data = {s1_read_q, (s1_read_q ? ram_dout_i : {DW{1'b0}})};

   qpu_tcm_rsp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DW + 1)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (s1_vld_q),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .cnt_o       (fifo_cnt)
   );

   assign rsp_valid_o = (fifo_cnt != '0);
   assign rsp_read_o  = fifo_head[DW];
   assign rsp_rdata_o = fifo_head[DW-1:0];
   assign pop         = rsp_valid_o & rsp_ready_i;

   //---------------------------------------------------------------------------
   // Light-sleep FSM. The idle counter only advances while awake; sleep is
   // entered on the same edge the counter reaches LS_IDLE. Any cmd_valid while
   // asleep wakes the macro on the next edge (cmd_ready stays low meanwhile).
   //---------------------------------------------------------------------------
   assign idle = ~cmd_valid_i & ~s1_vld_q & (fifo_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ls_state_q <= LS_AWAKE;
         idle_cnt_q <= '0;
      end else begin
         ls_state_q <= ls_state_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   always_comb begin
      ls_state_d = ls_state_q;
      idle_cnt_d = idle_cnt_q;

      if (!idle) begin
         idle_cnt_d = '0;
      end else if ((ls_state_q == LS_AWAKE) && (idle_cnt_q < ICW'(LS_IDLE))) begin
         idle_cnt_d = idle_cnt_q + ICW'(1);
      end

      case (ls_state_q)
         LS_AWAKE: begin
            if ((LS_IDLE != 0) && idle && (idle_cnt_d == ICW'(LS_IDLE))) begin
               ls_state_d = LS_SLEEP;
            end
         end
         LS_SLEEP: begin
            if (cmd_valid_i) ls_state_d = LS_AWAKE;
         end
         default: ls_state_d = LS_AWAKE;
      endcase
   end

   assign ram_ls_o = (ls_state_q == LS_SLEEP);

endmodule : qpu_tcm_ctrl
`default_nettype wire

// File: tb/tb_qpu_tcm_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_qpu_tcm_ctrl
// Purpose  : Directed self-checking bench for qpu_tcm_ctrl with an SRAM model,
//            a transaction-level reference model and literal spot checks.
// Revision : 1.0 - initial release
//==============================================================================
module tb_qpu_tcm_ctrl;

   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int MW      = 4;
   localparam int DEPTH   = 2;
   localparam int LS_IDLE = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_read;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [MW-1:0] cmd_wmask;
   logic          rsp_valid, rsp_ready, rsp_read;
   logic [DW-1:0] rsp_rdata;
   logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din, ram_dout;

   int n_vec = 0;
   int n_err = 0;
   int tb_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   qpu_tcm_ctrl #(
      .AW(AW), .DW(DW), .MW(MW), .DEPTH(DEPTH), .LS_IDLE(LS_IDLE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_read_i(cmd_read),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wmask_i(cmd_wmask),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_read_o(rsp_read),
      .rsp_rdata_o(rsp_rdata),
      .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wem_o(ram_wem), .ram_din_o(ram_din), .ram_dout_i(ram_dout),
      .ram_ls_o(ram_ls), .ram_ds_o(ram_ds), .ram_sd_o(ram_sd)
   );

   // SRAM macro model: byte-masked write, read data one cycle after cs.
   logic [DW-1:0] sram [1<<AW];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) begin
            for (int b = 0; b < MW; b++)
               if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
         end else begin
            ram_dout <= sram[ram_addr];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, tb_cyc);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model: list of outstanding responses tagged with acceptance
   // cycle (a response is visible two cycles after acceptance), a shadow
   // memory updated in command order, and the idle/light-sleep rules.
   //---------------------------------------------------------------------------
   typedef struct {
      int            cyc;
      bit            rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          mq[$];
   logic [DW-1:0] shadow [1<<AW];
   bit            m_ls;
   int            m_idle;

   initial begin : p_model
      int occ;
      bit vexp, pexp, rexp, aexp, idle;
      exp_t e;
      for (int i = 0; i < (1 << AW); i++) begin
         shadow[i] = '0;
      end
      m_ls = 0;
      m_idle = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("cs_in_reset", ram_cs, 0);
            mq.delete();
            m_ls = 0;
            m_idle = 0;
         end else begin
            occ  = mq.size();
            vexp = 0;
            if (occ > 0) vexp = (mq[0].cyc + 2 <= tb_cyc);
            pexp = vexp && rsp_ready;
            rexp = !m_ls && ((occ - int'(pexp)) < DEPTH);
            aexp = cmd_valid && rexp;
            idle = !cmd_valid && (occ == 0);

            check("rsp_valid", rsp_valid, vexp);
            check("cmd_ready", cmd_ready, rexp);
            check("ram_ls", ram_ls, m_ls);
            check("ram_cs", ram_cs, aexp);
            check("ram_we", ram_we, aexp && !cmd_read);
            check("cs_during_ls", ram_cs && ram_ls, 0);
            check("ram_ds_sd", {ram_ds, ram_sd}, 0);
            if (vexp) begin
               check("rsp_read", rsp_read, mq[0].rd);
               check("rsp_rdata", rsp_rdata, mq[0].data);
            end
            if (aexp) begin
               check("ram_addr", ram_addr, cmd_addr);
               check("ram_din", ram_din, cmd_wdata);
               check("ram_wem", ram_wem, cmd_read ? '0 : cmd_wmask);
            end

            if (pexp) void'(mq.pop_front());
            if (aexp) begin
               e.cyc = tb_cyc;
               e.rd  = cmd_read;
               if (cmd_read) begin
                  e.data = shadow[cmd_addr];
               end else begin
                  e.data = '0;
                  for (int b = 0; b < MW; b++)
                     if (cmd_wmask[b]) shadow[cmd_addr][8*b +: 8] = cmd_wdata[8*b +: 8];
               end
               mq.push_back(e);
            end

            if (m_ls) begin
               if (cmd_valid) m_ls = 0;
            end
            if (!idle) begin
               m_idle = 0;
            end else if (!m_ls) begin
               if (m_idle < LS_IDLE) m_idle++;
               if (LS_IDLE != 0 && m_idle == LS_IDLE) m_ls = 1;
            end
         end
      end
   end

   // Response log for ordering / continuity checks.
   int            log_cyc[$];
   logic [DW-1:0] log_dat[$];
   initial begin : p_log
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && rsp_ready) begin
            log_cyc.push_back(tb_cyc);
            log_dat.push_back(rsp_rdata);
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers; all return just after a rising edge.
   //---------------------------------------------------------------------------
   task automatic send(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m, output int acc_cyc, output int tries);
      cmd_valid = 1'b1;
      cmd_read  = rd;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wmask = m;
      acc_cyc   = -1;
      tries     = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         tries++;
         if (cmd_ready) acc_cyc = tb_cyc;
         @(posedge clk);
         #1;
         if (acc_cyc >= 0) break;
      end
      if (acc_cyc < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: addr %0h not accepted within 40 cycles", a);
      end
   endtask

   task automatic idle_cmd();
      cmd_valid = 1'b0;
      cmd_read  = 1'b0;
   endtask

   task automatic wait_rsp(output int rcyc, output bit rrd, output logic [DW-1:0] rdat);
      rcyc = -1;
      rrd  = 0;
      rdat = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            rcyc = tb_cyc;
            rrd  = rsp_read;
            rdat = rsp_rdata;
            break;
         end
      end
      if (rcyc < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL rsp_timeout: no response within 40 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : p_stim
      int ac, tr, rc, n_acc, stalls;
      bit rr;
      logic [DW-1:0] rd;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;
      for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_ram_ls", ram_ls, 0);
      @(posedge clk); #1;

      // 1: write then read, latency 2
      send(0, 12'h010, 32'hDEAD_BEEF, 4'hF, ac, tr);
      idle_cmd();
      wait_rsp(rc, rr, rd);
      check("t1_wr_latency", rc - ac, 2);
      check("t1_wr_rsp_read", rr, 0);
      check("t1_wr_rdata", rd, 0);
      send(1, 12'h010, '0, 4'h0, ac, tr);
      idle_cmd();
      wait_rsp(rc, rr, rd);
      check("t1_rd_latency", rc - ac, 2);
      check("t1_rd_rsp_read", rr, 1);
      check("t1_rd_rdata", rd, 32'hDEAD_BEEF);

      // 2: byte mask merge
      log_cyc.delete(); log_dat.delete();
      send(0, 12'h020, 32'h1122_3344, 4'hF, ac, tr);
      send(0, 12'h020, 32'hAABB_CCDD, 4'b0101, ac, tr);
      send(1, 12'h020, '0, 4'h0, ac, tr);
      idle_cmd();
      settle(6);
      check("t2_rsp_count", log_dat.size(), 3);
      if (log_dat.size() == 3) check("t2_merged", log_dat[2], 32'h11BB_33DD);

      // 3: streaming, 8 writes then 8 reads back-to-back
      log_cyc.delete(); log_dat.delete();
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send(0, AW'(12'h040 + i), 32'h0101_0101 * (i + 1), 4'hF, ac, tr);
         if (i > 0 && tr != 1) stalls++;
      end
      for (int i = 0; i < 8; i++) begin
         send(1, AW'(12'h040 + i), '0, 4'h0, ac, tr);
         if (tr != 1) stalls++;
      end
      idle_cmd();
      settle(6);
      check("t3_stalls", stalls, 0);
      check("t3_rsp_count", log_dat.size(), 16);
      if (log_dat.size() == 16) begin
         check("t3_rd_consecutive", log_cyc[15] - log_cyc[8], 7);
         check("t3_all_consecutive", log_cyc[15] - log_cyc[0], 15);
         for (int i = 0; i < 8; i++)
            check("t3_rd_data", log_dat[8 + i], 32'h0101_0101 * (i + 1));
      end

      // 4: backpressure
      log_cyc.delete(); log_dat.delete();
      rsp_ready = 1'b0;
      n_acc = 0;
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 12'h040;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tr = int'(cmd_ready);
         @(posedge clk); #1;
         if (tr != 0) begin
            n_acc++;
            cmd_addr = AW'(12'h040 + n_acc);
         end
      end
      check("t4_accepted", n_acc, DEPTH);
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && n_acc < 4; i++) begin
         @(negedge clk);
         tr = int'(cmd_ready);
         @(posedge clk); #1;
         if (tr != 0) begin
            n_acc++;
            cmd_addr = AW'(12'h040 + n_acc);
         end
      end
      idle_cmd();
      settle(6);
      check("t4_rsp_count", log_dat.size(), 4);
      if (log_dat.size() == 4)
         for (int i = 0; i < 4; i++)
            check("t4_rsp_order", log_dat[i], 32'h0101_0101 * (i + 1));

      // 5: light sleep entry after LS_IDLE idle cycles, 1-cycle wake
      send(1, 12'h010, '0, 4'h0, ac, tr);
      idle_cmd();
      wait_rsp(rc, rr, rd);
      for (int i = 0; i < LS_IDLE; i++) begin
         @(negedge clk);
         check("t5_awake_while_counting", ram_ls, 0);
      end
      @(negedge clk);
      check("t5_ls_entered", ram_ls, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 12'h020;
      @(negedge clk);
      check("t5_wake_ready", cmd_ready, 0);
      check("t5_wake_cs", ram_cs, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_ls_exit", ram_ls, 0);
      check("t5_accept_ready", cmd_ready, 1);
      @(posedge clk); #1;
      idle_cmd();
      wait_rsp(rc, rr, rd);
      check("t5_rdata", rd, 32'h11BB_33DD);

      // 6: reset with two responses pending
      rsp_ready = 1'b0;
      send(1, 12'h010, '0, 4'h0, ac, tr);
      send(1, 12'h020, '0, 4'h0, ac, tr);
      idle_cmd();
      settle(3);
      @(negedge clk);
      check("t6_pending", rsp_valid, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      log_cyc.delete(); log_dat.delete();
      @(negedge clk);
      check("t6_rsp_valid", rsp_valid, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      settle(5);
      check("t6_no_stale", log_dat.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_qpu_tcm_ctrl
`default_nettype wire
